// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// FSM state encoding used by mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter.
// master = arbiter view, slave = requesters plus memory.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_wr;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             done;
    logic [NUM_REQ-1:0]             err;
    logic [DATA_W-1:0]              rdata;
    logic                           mem_rd;
    logic                           mem_wr;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic [DATA_W-1:0]              mem_rdata;
    logic                           mem_ready;

    modport master (
        input  req, req_wr, req_addr, req_wdata,
        input  mem_rdata, mem_ready,
        output done, err, rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata,
        output mem_rdata, mem_ready,
        input  done, err, rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_picker.sv
// Round-robin picker: first set request after last_grant.
// Purely combinational; the caller registers the result.
module rr_picker #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // Scan from last_grant+1 upward, wrapping, first hit wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = (int'(last_grant) + i) % NUM_REQ;
            if (!valid && req[IW'(j)]) begin
                valid          = 1'b1;
                idx            = IW'(j);
                grant[IW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between requesters.
// One access in flight, ready handshake with optional timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    arb_state_e         state;
    logic [IW-1:0]      last_grant;
    logic [NUM_REQ-1:0] grant_q;
    logic [CW-1:0]      cnt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    logic [IW-1:0]      idx_q;
    logic               mem_rd_q;
    logic               mem_wr_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic [DATA_W-1:0]  rdata_q;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (bus.req),
        .last_grant(last_grant),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .valid     (pick_valid)
    );

    // Arbitration FSM; every bus-facing output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= IW'(NUM_REQ - 1);
            grant_q     <= '0;
            idx_q       <= '0;
            cnt         <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q       <= pick_idx;
                        grant_q     <= pick_grant;
                        mem_rd_q    <= ~bus.req_wr[pick_idx];
                        mem_wr_q    <= bus.req_wr[pick_idx];
                        mem_addr_q  <= bus.req_addr[pick_idx];
                        mem_wdata_q <= bus.req_wdata[pick_idx];
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        done_q   <= grant_q;
                        rdata_q  <= mem_rd_q ? bus.mem_rdata : '0;
                        state    <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CLAST) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        done_q   <= grant_q;
                        err_q    <= grant_q;
                        rdata_q  <= '0;
                        state    <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    done_q     <= '0;
                    err_q      <= '0;
                    rdata_q    <= '0;
                    last_grant <= idx_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;

endmodule
